// File: rtl/dom_freq_picker.sv
// Streaming dominant-frequency picker: scans one spectrum frame per window, tracks the
// strongest eligible bin, and publishes its index once it holds steady over several frames.
module dom_freq_picker #(
  parameter int unsigned MAG_W         = 16,
  parameter int unsigned MAX_BINS      = 512,
  parameter int unsigned MIN_BIN       = 2,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bin_valid,
  input  logic             bin_first,
  input  logic             bin_last,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic [MAG_W-1:0] mag_floor,
  output logic [9:0]       peak,
  output logic [MAG_W-1:0] peak_mag,
  output logic             newDomFreq,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [9:0] LAST_IDX = 10'(MAX_BINS - 1);
  localparam logic [9:0] MIN_IDX  = 10'(MIN_BIN);
  localparam logic [2:0] SF       = 3'(STABLE_FRAMES);

  state_t           state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic [MAG_W-1:0] max_q, max_d;
  logic [9:0]       max_idx_q, max_idx_d;
  logic             none_q, none_d;
  logic             res_valid_q, res_valid_d;
  logic [9:0]       res_idx_q, res_idx_d;
  logic [MAG_W-1:0] res_mag_q, res_mag_d;
  logic             res_none_q, res_none_d;
  logic [2:0]       stable_cnt_q, stable_cnt_d;
  logic [9:0]       prev_cand_q, prev_cand_d;
  logic [9:0]       peak_q, peak_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic             new_dom_freq_q, new_dom_freq_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic [9:0]       cur_idx;
  logic [MAG_W-1:0] base_max;
  logic [9:0]       base_idx;
  logic             base_none;
  logic             take;
  logic [MAG_W-1:0] cand_mag;
  logic [9:0]       cand_idx;
  logic             cand_none;
  logic [9:0]       diff;
  logic [2:0]       cnt_next;

  // bin_first restarts the running max in the same cycle, so the incoming bin
  // is compared against a cleared max rather than the stale one.
  always_comb begin
    accept    = bin_valid && ((state_q == SCAN) || bin_first);
    cur_idx   = bin_first ? '0 : idx_q;
    base_max  = bin_first ? '0 : max_q;
    base_idx  = bin_first ? '0 : max_idx_q;
    base_none = bin_first || none_q;
    take      = (cur_idx >= MIN_IDX) && (bin_mag > base_max);
    cand_mag  = take ? bin_mag : base_max;
    cand_idx  = take ? cur_idx : base_idx;
    cand_none = take ? 1'b0 : base_none;

    state_d     = state_q;
    idx_d       = idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    none_d      = none_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_mag_d   = res_mag_q;
    res_none_d  = res_none_q;
    frame_err_d = 1'b0;

    if (accept) begin
      idx_d     = cur_idx + 10'd1;
      max_d     = cand_mag;
      max_idx_d = cand_idx;
      none_d    = cand_none;
      if ((state_q == SCAN) && bin_first) begin
        frame_err_d = 1'b1;
      end
      if (bin_last) begin
        res_valid_d = 1'b1;
        res_idx_d   = cand_idx;
        res_mag_d   = cand_mag;
        res_none_d  = cand_none;
        state_d     = IDLE;
      end else if (cur_idx == LAST_IDX) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d     = SCAN;
      end
    end
  end

  always_comb begin
    stable_cnt_d   = stable_cnt_q;
    prev_cand_d    = prev_cand_q;
    peak_d         = peak_q;
    peak_mag_d     = peak_mag_q;
    new_dom_freq_d = 1'b0;
    diff           = (res_idx_q > prev_cand_q) ? (res_idx_q - prev_cand_q)
                                               : (prev_cand_q - res_idx_q);
    cnt_next       = '0;

    if (res_valid_q) begin
      if (res_none_q || (res_mag_q < mag_floor)) begin
        stable_cnt_d = '0;
      end else begin
        if ((stable_cnt_q == 3'd0) || (diff > 10'd1)) begin
          cnt_next = 3'd1;
        end else if (stable_cnt_q >= SF) begin
          cnt_next = SF;
        end else begin
          cnt_next = stable_cnt_q + 3'd1;
        end
        stable_cnt_d = cnt_next;
        prev_cand_d  = res_idx_q;
        if (cnt_next == SF) begin
          peak_d         = res_idx_q;
          peak_mag_d     = res_mag_q;
          new_dom_freq_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      max_q          <= '0;
      max_idx_q      <= '0;
      none_q         <= 1'b1;
      res_valid_q    <= 1'b0;
      res_idx_q      <= '0;
      res_mag_q      <= '0;
      res_none_q     <= 1'b1;
      stable_cnt_q   <= '0;
      prev_cand_q    <= '0;
      peak_q         <= '0;
      peak_mag_q     <= '0;
      new_dom_freq_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      max_q          <= max_d;
      max_idx_q      <= max_idx_d;
      none_q         <= none_d;
      res_valid_q    <= res_valid_d;
      res_idx_q      <= res_idx_d;
      res_mag_q      <= res_mag_d;
      res_none_q     <= res_none_d;
      stable_cnt_q   <= stable_cnt_d;
      prev_cand_q    <= prev_cand_d;
      peak_q         <= peak_d;
      peak_mag_q     <= peak_mag_d;
      new_dom_freq_q <= new_dom_freq_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign peak       = peak_q;
  assign peak_mag   = peak_mag_q;
  assign newDomFreq = new_dom_freq_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == SCAN);

endmodule

// File: tb/tb_dom_freq_picker.sv
// Bench for dom_freq_picker: frame table, hand-written abort/reset sequences, and random
// frames checked cycle by cycle against a frame-level reference model.
module tb_dom_freq_picker;
  localparam int MAG_W    = 16;
  localparam int MAX_BINS = 512;
  localparam int MIN_BIN  = 2;
  localparam int SF       = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bin_valid = 1'b0, bin_first = 1'b0, bin_last = 1'b0;
  logic [MAG_W-1:0] bin_mag = '0;
  logic [MAG_W-1:0] mag_floor = 16'd50;
  logic [9:0]       peak;
  logic [MAG_W-1:0] peak_mag;
  logic             newDomFreq, frame_err, busy;

  dom_freq_picker #(.MAG_W(MAG_W), .MAX_BINS(MAX_BINS), .MIN_BIN(MIN_BIN),
                    .STABLE_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_first(bin_first),
    .bin_last(bin_last), .bin_mag(bin_mag), .mag_floor(mag_floor), .peak(peak),
    .peak_mag(peak_mag), .newDomFreq(newDomFreq), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  bit in_scan = 0;
  int cur = 0;
  int fm[MAX_BINS];
  int src[MAX_BINS];
  int m_stable = 0, m_prev = 0, m_peak = 0, m_mag = 0;
  bit chk_en = 0;
  bit ev_pub[int];
  int ev_pk[int];
  int ev_mg[int];
  bit ev_err[int];
  int pub_seen = 0, err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (ev_pub.exists(cyc)) begin
        m_peak = ev_pk[cyc];
        m_mag  = ev_mg[cyc];
      end
      check("newDomFreq", 32'(newDomFreq), 32'(ev_pub.exists(cyc)));
      check("frame_err", 32'(frame_err), 32'(ev_err.exists(cyc)));
      check("peak", 32'(peak), m_peak);
      check("peak_mag", 32'(peak_mag), m_mag);
      check("busy", 32'(busy), 32'(in_scan));
    end
    if (newDomFreq === 1'b1) pub_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic frame_done(input int e);
    int best, bm, d;
    best = -1;
    bm = 0;
    for (int i = MIN_BIN; i <= cur; i++) begin
      if (fm[i] > bm) begin
        bm = fm[i];
        best = i;
      end
    end
    if (best < 0 || bm < int'(mag_floor)) begin
      m_stable = 0;
    end else begin
      d = (best > m_prev) ? best - m_prev : m_prev - best;
      if (m_stable == 0 || d > 1) m_stable = 1;
      else m_stable = (m_stable + 1 > SF) ? SF : m_stable + 1;
      m_prev = best;
      if (m_stable == SF) begin
        ev_pub[e + 1] = 1'b1;
        ev_pk[e + 1]  = best;
        ev_mg[e + 1]  = bm;
      end
    end
  endtask

  task automatic model_bin(input bit first, input bit last, input int mag, input int e);
    if (first) begin
      if (in_scan) ev_err[e] = 1'b1;
      in_scan = 1;
      cur = 0;
    end else if (!in_scan) begin
      return;
    end
    fm[cur] = mag;
    if (last) begin
      frame_done(e);
      in_scan = 0;
    end else if (cur == MAX_BINS - 1) begin
      ev_err[e] = 1'b1;
      in_scan = 0;
    end else begin
      cur++;
    end
  endtask

  task automatic drive_bin(input bit first, input bit last, input int mag, input int gap_pct);
    logic [MAG_W-1:0] m16;
    for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
      @(negedge clk);
      bin_valid = 1'b0;
      bin_first = 1'($urandom_range(0, 1));
      bin_last  = 1'($urandom_range(0, 1));
      bin_mag   = 16'($urandom);
    end
    m16 = mag[MAG_W-1:0];
    @(negedge clk);
    bin_valid = 1'b1;
    bin_first = first;
    bin_last  = last;
    bin_mag   = m16;
    model_bin(first, last, int'(m16), cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bin_valid = 1'b0;
      bin_first = 1'b0;
      bin_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input bit has_last, input int gap_pct);
    for (int i = 0; i < n; i++) drive_bin(i == 0, has_last && (i == n - 1), src[i], gap_pct);
  endtask

  task automatic fill(input int base, input int i1, input int i2, input int m);
    for (int i = 0; i < MAX_BINS; i++) src[i] = base;
    if (i1 >= 0) src[i1] = m;
    if (i2 >= 0) src[i2] = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bin_valid = 1'b0;
    bin_first = 1'b0;
    bin_last = 1'b0;
    in_scan = 0;
    m_stable = 0;
    m_prev = 0;
    m_peak = 0;
    m_mag = 0;
    ev_pub.delete();
    ev_pk.delete();
    ev_mg.delete();
    ev_err.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit rst;
    int nbins;
    int i1;
    int i2;
    int mag;
    int gap;
    int exp_pub;
    int exp_peak;
    int exp_mag;
    int exp_stable;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, e0, center, len, pk, kind, gap;

    tbl[0]  = '{0, 512, 100, -1, 900,  0,  0, 0,   0,   1};
    tbl[1]  = '{0, 512, 100, -1, 900,  20, 0, 0,   0,   2};
    tbl[2]  = '{0, 512, 100, -1, 900,  0,  1, 100, 900, 3};
    tbl[3]  = '{0, 512, 101, -1, 900,  0,  1, 101, 900, 3};
    tbl[4]  = '{1, 512, 100, -1, 900,  0,  0, 0,   0,   1};
    tbl[5]  = '{0, 512, 101, -1, 900,  0,  0, 0,   0,   2};
    tbl[6]  = '{0, 512, 102, -1, 900,  0,  1, 102, 900, 3};
    tbl[7]  = '{0, 512, 110, -1, 900,  0,  0, 102, 900, 1};
    tbl[8]  = '{0, 512, 110, -1, 900,  20, 0, 102, 900, 2};
    tbl[9]  = '{0, 512, 110, -1, 900,  0,  1, 110, 900, 3};
    tbl[10] = '{0, 512, 1,   -1, 5000, 0,  0, 110, 900, 0};
    tbl[11] = '{0, 512, 1,   -1, 5000, 20, 0, 110, 900, 0};
    tbl[12] = '{0, 512, 1,   -1, 5000, 0,  0, 110, 900, 0};
    tbl[13] = '{0, 512, 40,  60, 700,  0,  0, 110, 900, 1};
    tbl[14] = '{0, 512, 40,  60, 700,  20, 0, 110, 900, 2};
    tbl[15] = '{0, 512, 40,  60, 700,  0,  1, 40,  700, 3};
    tbl[16] = '{0, 512, 511, -1, 800,  0,  0, 40,  700, 1};
    tbl[17] = '{0, 512, 511, -1, 800,  20, 0, 40,  700, 2};
    tbl[18] = '{0, 512, 511, -1, 800,  0,  1, 511, 800, 3};
    tbl[19] = '{0, 1,   0,   -1, 9999, 0,  0, 511, 800, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_peak", 32'(peak), 0);
    check("reset_peak_mag", 32'(peak_mag), 0);
    check("reset_newDomFreq", 32'(newDomFreq), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_stable_cnt", 32'(dut.stable_cnt_q), 0);
    reset = 1'b0;
    chk_en = 1;

    for (int k = 0; k < 20; k++) begin
      if (tbl[k].rst) do_reset();
      fill(10, tbl[k].i1, tbl[k].i2, tbl[k].mag);
      p0 = pub_seen;
      send_frame(tbl[k].nbins, 1'b1, tbl[k].gap);
      idle(4);
      check($sformatf("tbl%0d_pub", k), pub_seen - p0, tbl[k].exp_pub);
      check($sformatf("tbl%0d_peak", k), 32'(peak), tbl[k].exp_peak);
      check($sformatf("tbl%0d_peak_mag", k), 32'(peak_mag), tbl[k].exp_mag);
      check($sformatf("tbl%0d_stable", k), 32'(dut.stable_cnt_q), tbl[k].exp_stable);
    end

    // back-to-back frames, then a restart abort at index 200
    do_reset();
    fill(10, 300, -1, 1000);
    p0 = pub_seen;
    send_frame(512, 1'b1, 0);
    send_frame(512, 1'b1, 0);
    send_frame(512, 1'b1, 0);
    idle(4);
    check("b2b_pub", pub_seen - p0, 1);
    check("b2b_peak", 32'(peak), 300);
    check("b2b_stable", 32'(dut.stable_cnt_q), 3);
    e0 = err_seen;
    p0 = pub_seen;
    send_frame(200, 1'b0, 0);
    drive_bin(1'b1, 1'b0, src[0], 0);
    idle(3);
    check("restart_err", err_seen - e0, 1);
    check("restart_busy", 32'(busy), 1);
    check("restart_stable", 32'(dut.stable_cnt_q), 3);
    check("restart_peak", 32'(peak), 300);
    for (int i = 1; i < MAX_BINS; i++) drive_bin(1'b0, i == MAX_BINS - 1, src[i], 0);
    idle(4);
    check("restart_pub", pub_seen - p0, 1);
    check("restart_peak2", 32'(peak), 300);

    // overflow abort, then a stray bin in IDLE
    e0 = err_seen;
    p0 = pub_seen;
    send_frame(512, 1'b0, 0);
    idle(3);
    check("ovf_err", err_seen - e0, 1);
    check("ovf_busy", 32'(busy), 0);
    check("ovf_stable", 32'(dut.stable_cnt_q), 3);
    check("ovf_peak", 32'(peak), 300);
    check("ovf_peak_mag", 32'(peak_mag), 1000);
    drive_bin(1'b0, 1'b1, 60000, 0);
    idle(3);
    check("stray_pub", pub_seen - p0, 0);
    check("stray_busy", 32'(busy), 0);

    // reset at bin 300 of the third agreeing frame
    do_reset();
    fill(10, 100, -1, 900);
    send_frame(512, 1'b1, 0);
    send_frame(512, 1'b1, 0);
    for (int i = 0; i < 300; i++) drive_bin(i == 0, 1'b0, src[i], 0);
    p0 = pub_seen;
    e0 = err_seen;
    do_reset();
    idle(4);
    check("rst_mid_pub", pub_seen - p0, 0);
    check("rst_mid_err", err_seen - e0, 0);
    check("rst_mid_peak", 32'(peak), 0);
    check("rst_mid_peak_mag", 32'(peak_mag), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_stable", 32'(dut.stable_cnt_q), 0);

    // random frames against the reference model
    center = int'($urandom_range(2, 500));
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) center = int'($urandom_range(0, 511));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 511)) : 512;
      pk = center + int'($urandom_range(0, 2)) - 1;
      if (pk < 0) pk = 0;
      if (pk > len - 1) pk = len - 1;
      for (int i = 0; i < MAX_BINS; i++) src[i] = int'($urandom_range(0, 60));
      src[pk] = int'($urandom_range(30, 3000));
      if ($urandom_range(0, 5) == 0 && pk + 40 < len) src[pk + 40] = src[pk];
      gap = ($urandom_range(0, 1) == 0) ? 0 : 25;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) send_frame(int'($urandom_range(1, len)), 1'b0, gap);
      else if (kind == 1) drive_bin(1'b0, 1'($urandom_range(0, 1)), int'($urandom), gap);
      else send_frame(len, 1'b1, gap);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dom_freq_picker.md
# dom_freq_picker

Streaming dominant-frequency detector that sits directly upstream of the tuning comparator FSM. It consumes one spectrum frame of magnitude bins per analysis window and finds the highest-magnitude bin above a noise floor. It requires the result to be stable over several consecutive frames. It then publishes the 10-bit bin index on `peak` with a one-cycle `newDomFreq` strobe for the comparator.

## Interface
- `MAG_W`, 16: magnitude width in bits.
- `MAX_BINS`, 512: maximum bins per frame (≤1024); the bin index is 10 bits.
- `MIN_BIN`, 2: bins with index < MIN_BIN (DC/rumble) are never candidates.
- `STABLE_FRAMES`, 3: consecutive agreeing frames required before publishing (1..7).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `bin_valid` in 1: a bin is presented this cycle.
- `bin_first` in 1: qualifies `bin_valid`; first bin of frame (index 0).
- `bin_last` in 1: qualifies `bin_valid`; last bin of frame.
- `bin_mag` in MAG_W: bin magnitude, unsigned.
- `mag_floor` in MAG_W: minimum magnitude for a valid peak; quasi-static.
- `peak` out 10: published dominant bin index.
- `peak_mag` out MAG_W: magnitude of the published bin.
- `newDomFreq` out 1: one-cycle strobe when `peak` updates.
- `frame_err` out 1: one-cycle strobe on an aborted frame.
- `busy` out 1: high while in SCAN.

## Operation
- Scanner FSM states:
  - IDLE → SCAN on `bin_valid & bin_first & ~bin_last`.
  - `bin_valid & bin_first & bin_last` is a complete 1-bin frame; stay in IDLE and emit a result.
  - SCAN → IDLE on `bin_valid & bin_last`.
- In IDLE, bins without `bin_first` are ignored.
- Bin index counter:
  - Set to 0 on `bin_first`.
  - Increments once per accepted bin.
  - `bin_valid` low stalls the counter; gaps are legal.
- Max tracking:
  - Applies only to bins with index ≥ MIN_BIN.
  - Replace the running maximum only when `bin_mag >` the running max (strict), so ties keep the lowest index.
  - The running max is cleared to 0 with a "none" flag on `bin_first`.
- Aborts, each of which pulses `frame_err` and discards the frame:
  - `bin_first` while in SCAN. The frame is restarted with this bin as index 0, and the FSM stays in SCAN.
  - The index would reach MAX_BINS without `bin_last`. The FSM goes to IDLE.
- Frame result: on the `bin_last` cycle, the candidate (index, magnitude), including the last bin itself, is registered into a result stage with `res_valid`.
- Stability stage (cycle after `res_valid`):
  - If "none" or candidate magnitude < `mag_floor`: `stable_cnt` ← 0; no publish.
  - Else if `stable_cnt == 0` or |cand − prev_cand| > 1: `stable_cnt` ← 1.
  - Else: `stable_cnt` ← min(`stable_cnt` + 1, STABLE_FRAMES).
  - `prev_cand` ← cand whenever the candidate is valid.
  - Publish when the new `stable_cnt` == STABLE_FRAMES: `peak` ← cand, `peak_mag` ← magnitude, `newDomFreq` ← 1 for one cycle.
  - Once stable, every further agreeing frame publishes again.
- Magnitude comparisons are unsigned, at MAG_W bits. The |Δ| is computed on 10-bit unsigned indices with no wrap (larger minus smaller).

## Timing
- Reset values: `peak` = 0, `peak_mag` = 0, `newDomFreq` = 0, `frame_err` = 0, `busy` = 0, `stable_cnt` = 0, `prev_cand` = 0, FSM in IDLE, `res_valid` = 0.
- Reset mid-frame discards all partial state; no strobes are emitted.
- Latency: `bin_last` is sampled at edge E. `newDomFreq`, `peak` and `peak_mag` are valid in the cycle after edge E+1 (two edges after `bin_last`).
- `peak` and `peak_mag` hold until the next publish.
- Back-to-back frames: `bin_first` on the cycle immediately after `bin_last` is accepted. The result and stability stages run concurrently with the new scan; there is no backpressure.
- `frame_err` is asserted the cycle after the offending bin. An abort never touches `stable_cnt`.
- `newDomFreq` and `frame_err` can never be high for more than one consecutive cycle per event.

## Test plan
- Reset, then three frames of 512 bins with bin 100 = 900 and all others 10, with `mag_floor` = 50:
  - No strobe after frames 1 and 2.
  - `newDomFreq` pulses once, two edges after frame 3's `bin_last`, with `peak` = 100 and `peak_mag` = 900.
- Drifting peak: peaks at 100, 101, 102, then 110, 110, 110:
  - A publish occurs at `peak` = 102 after the third frame.
  - `stable_cnt` resets at 110, and a publish at 110 occurs only after the sixth frame.
- Floor and MIN_BIN: bin 1 = 5000 with all others below `mag_floor` = 50, over 3 frames. Required: no publish, `stable_cnt` = 0.
- Tie and edges:
  - Bins 40 and 60 both = 700 gives `peak` = 40.
  - A peak in the `bin_last` bin (511) is found correctly.
  - A single-bin frame (`bin_first` & `bin_last`) at index 0 produces no candidate.
- Aborts:
  - `bin_first` at index 200 mid-frame pulses `frame_err` and restarts.
  - 512 bins without `bin_last` pulse `frame_err` and return to IDLE.
  - In both cases, previously published `peak` and `stable_cnt` are unchanged.
- Throughput and reset:
  - Back-to-back frames with zero gap cycles, and `bin_valid` gaps, give identical results.
  - `reset` asserted at bin 300 of the third agreeing frame yields no publish, and all outputs are 0.
